onehot_decoder_fifo: RTL and testbench

// - Inverse of the 8:3 priority encoder: turns a binary index back into a one-hot 8-bit vector.
// - Buffers index requests in a small FIFO with valid/ready handshakes on both sides.
// - Sits between the encoder-side index producer and a downstream one-hot select/grant consumer.

---
 rtl/onehot_decoder_fifo.sv | 86 ++++++++
 tb/tb_onehot_decoder_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_fifo.sv
// Small valid/ready FIFO of {en, idx} requests, decoded to a one-hot vector at the head.
// Define DEC_THERMO_EN to add the out_thermo thermometer-code output.
module onehot_decoder_fifo #(
    parameter int IDX_W = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic                     in_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(1<<IDX_W)-1:0]    out_onehot,
    output logic [$clog2(DEPTH):0]   level
`ifdef DEC_THERMO_EN
    ,
    output logic [(1<<IDX_W)-1:0]    out_thermo
`endif
);

    localparam int OUT_W = 1 << IDX_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [IDX_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               head_en;
    logic [IDX_W-1:0]   head_idx;
    logic [OUT_W-1:0]   head_onehot;

    // Full blocks pushes outright, even when a pop happens on the same edge.
    assign in_ready  = (level != FULL_LEVEL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Entry storage needs no reset: the head is masked by out_valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {in_en, in_idx};
        end
    end

    assign {head_en, head_idx} = mem[rd_ptr];

    always_comb begin
        head_onehot = '0;
        if (out_valid && head_en) begin
            head_onehot[head_idx] = 1'b1;
        end
    end

    assign out_onehot = head_onehot;

`ifdef DEC_THERMO_EN
    // Bits [idx:0] set: the one-hot bit plus every bit below it.
    assign out_thermo = (out_valid && head_en) ? (head_onehot | (head_onehot - OUT_W'(1))) : '0;
`endif

endmodule

// File: tb/tb_onehot_decoder_fifo.sv
// Self-checking bench for onehot_decoder_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_onehot_decoder_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic       in_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [2:0] level;
`ifdef DEC_THERMO_EN
    logic [7:0] out_thermo;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a queue of {en, idx}.
    logic [3:0] model_q [$];

    always #5 clk = ~clk;

    onehot_decoder_fifo #(.IDX_W(3), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .level      (level)
`ifdef DEC_THERMO_EN
        ,
        .out_thermo (out_thermo)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_output();
        int         n;
        logic [7:0] exp_onehot;
        logic [7:0] exp_thermo;
        n = model_q.size();
        exp_onehot = 8'h00;
        exp_thermo = 8'h00;
        if (n > 0 && model_q[0][3]) begin
            exp_onehot = 8'(2 ** int'(model_q[0][2:0]));
            exp_thermo = 8'(2 ** (int'(model_q[0][2:0]) + 1) - 1);
        end
        check_val("level", 32'(level), 32'(n));
        check_val("out_valid", 32'(out_valid), 32'(n > 0));
        check_val("in_ready", 32'(in_ready), 32'(n < DEPTH));
        check_val("out_onehot", 32'(out_onehot), 32'(exp_onehot));
`ifdef DEC_THERMO_EN
        check_val("out_thermo", 32'(out_thermo), 32'(exp_thermo));
`else
        if (exp_thermo == 8'hFF) exp_thermo = 8'h00;
`endif
    endtask

    // One clock: drive at negedge, advance the model at posedge, check 1 time unit later.
    task automatic apply_stimulus(input logic v, input logic e, input logic [2:0] i,
                                  input logic r, input logic rs, output logic accepted);
        logic m_push;
        logic m_pop;
        @(negedge clk);
        in_valid  = v;
        in_en     = e;
        in_idx    = i;
        out_ready = r;
        rst       = rs;
        m_push = !rs && v && (model_q.size() < DEPTH);
        m_pop  = !rs && r && (model_q.size() > 0);
        @(posedge clk);
        if (rs) begin
            model_q.delete();
        end else begin
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back({e, i});
        end
        accepted = m_push;
        #1;
        check_output();
    endtask

    initial begin
        logic       acc;
        logic [2:0] held_idx;
        int         k;

        in_valid = 1'b0; in_en = 1'b0; in_idx = 3'd0; out_ready = 1'b0; rst = 1'b1;

        // Reset, then idle
        apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, acc);
        for (int c = 0; c < 5; c++) apply_stimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, acc);

        // Stream idx 0..7 with the consumer always ready
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b1, 3'(i), 1'b1, 1'b0, acc);
            check_val("stream_onehot", 32'(out_onehot), 32'(8'h01 << i));
        end
        apply_stimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, acc);

        // Fill with consumer stalled; the 5th word is held by the producer
        k = 0;
        held_idx = 3'd1;
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(1'b1, 1'b1, held_idx, 1'b0, 1'b0, acc);
            if (acc) begin
                k++;
                held_idx = held_idx + 3'd1;
            end
        end
        check_val("fill_accepted", 32'(k), 32'd4);
        check_val("fill_level", 32'(level), 32'd4);
        check_val("fill_in_ready", 32'(in_ready), 32'd0);

        // Full with push+pop on one edge: pop only
        apply_stimulus(1'b1, 1'b1, held_idx, 1'b1, 1'b0, acc);
        check_val("full_pushpop_acc", 32'(acc), 32'd0);
        check_val("full_pushpop_level", 32'(level), 32'd3);
        apply_stimulus(1'b1, 1'b1, held_idx, 1'b0, 1'b0, acc);
        check_val("held_word_acc", 32'(acc), 32'd1);
        check_val("held_word_level", 32'(level), 32'd4);

        // Drain
        for (int c = 0; c < 5; c++) apply_stimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, acc);

        // en=0 emits zero, then en=1 idx=5
        apply_stimulus(1'b1, 1'b0, 3'd5, 1'b0, 1'b0, acc);
        check_val("en0_onehot", 32'(out_onehot), 32'h00);
        apply_stimulus(1'b1, 1'b1, 3'd5, 1'b1, 1'b0, acc);
        check_val("en1_onehot", 32'(out_onehot), 32'h20);
`ifdef DEC_THERMO_EN
        check_val("en1_thermo", 32'(out_thermo), 32'h3F);
`endif
        apply_stimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, acc);

        // Mid-stream reset discards buffered words
        for (int c = 0; c < 3; c++) apply_stimulus(1'b1, 1'b1, 3'(c + 2), 1'b0, 1'b0, acc);
        apply_stimulus(1'b1, 1'b1, 3'd7, 1'b0, 1'b1, acc);
        check_val("rst_level", 32'(level), 32'd0);
        for (int c = 0; c < 3; c++) apply_stimulus(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, acc);

        // Random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                           3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
                           1'($urandom_range(0, 60) == 0), acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
